// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port SRAM model: clear FSM states,
// collision-mode constants and the byte-merge used by the write and collision paths.
package sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int COLL_READ_OLD    = 0;
    localparam int COLL_WRITE_FIRST = COLL_READ_OLD + 1;

    // Callers zero-extend their word and mask to this width and truncate the result.
    localparam int MERGE_MAX_W = 1024;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] mask
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_W / 8; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line of STAGES registers carrying {valid, data}; each stage
// loads data only with a valid word, so the output holds the last delivered read.
module sram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ reset;
            assign out_valid   = in_valid;
            assign out_data    = in_data;
        end else begin : g_delay
            logic [STAGES-1:0] valid_q, valid_d;
            logic [WIDTH-1:0]  data_q [STAGES];
            logic [WIDTH-1:0]  data_d [STAGES];

            always_comb begin
                valid_d[0] = in_valid;
                data_d[0]  = in_valid ? in_data : data_q[0];
                for (int s = 1; s < STAGES; s++) begin
                    valid_d[s] = valid_q[s-1];
                    data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign out_data  = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sram_dp_model.sv
// Simple-dual-port SRAM model: byte-enabled write port, pipelined read port with
// selectable collision policy, and a one-word-per-cycle clear engine.
module sram_dp_model
    import sram_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 8,
    parameter int DEPTH_LOG      = $clog2(DEPTH),
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chip_select,
    input  logic                 write_enable,
    input  logic [WIDTH/8-1:0]   byte_enable,
    input  logic [DEPTH_LOG-1:0] wr_address,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 rd_en,
    input  logic [DEPTH_LOG-1:0] rd_address,
    output logic [WIDTH-1:0]     data_out,
    output logic                 rd_valid,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam logic [DEPTH_LOG:0]   DEPTH_LIM = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG-1:0] LAST_PTR  = DEPTH_LOG'(DEPTH - 1);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [DEPTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic                 rd_valid0_q, rd_valid0_d;
    logic [WIDTH-1:0]     rd_data0_q, rd_data0_d;

    logic             wr_in_range, rd_in_range;
    logic             wr_fire, rd_fire;
    logic [WIDTH-1:0] wr_word, rd_word;

    assign wr_in_range = {1'b0, wr_address} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_address} < DEPTH_LIM;
    assign wr_fire     = chip_select & write_enable & ~busy_q & wr_in_range;
    assign rd_fire     = chip_select & rd_en & ~busy_q;

    // Out-of-range reads still issue and return zero.
    always_comb begin
        wr_word = '0;
        rd_word = '0;
        if (wr_in_range) begin
            wr_word = WIDTH'(byte_merge(MERGE_MAX_W'(mem_q[wr_address]),
                                        MERGE_MAX_W'(data_in),
                                        (MERGE_MAX_W / 8)'(byte_enable)));
        end
        if (rd_in_range) begin
            rd_word = mem_q[rd_address];
            if (COLLISION_MODE == COLL_WRITE_FIRST && wr_fire && rd_address == wr_address) begin
                rd_word = wr_word;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        mem_d       = mem_q;
        rd_valid0_d = rd_fire;
        rd_data0_d  = rd_fire ? rd_word : rd_data0_q;

        if (wr_fire) begin
            mem_d[wr_address] = wr_word;
        end

        case (state_q)
            IDLE: begin
                if (chip_select && clear_req) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + DEPTH_LOG'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
            rd_valid0_q <= 1'b0;
            rd_data0_q  <= '0;
            // NOTE: the array is reset on purpose; this is a behavioural model, not a macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            rd_valid0_q <= rd_valid0_d;
            rd_data0_q  <= rd_data0_d;
            mem_q       <= mem_d;
        end
    end

    assign busy = busy_q;

    sram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_valid0_q),
        .in_data   (rd_data0_q),
        .out_valid (rd_valid),
        .out_data  (data_out)
    );

endmodule

// File: tb/tb_sram_dp_model.sv
// Directed bench for sram_dp_model: four instances share stimulus to cover
// latency 1/3, both collision modes and a non-power-of-2 depth.
module tb_sram_dp_model;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, we, re, clr;
    logic [3:0]  be;
    logic [2:0]  wa, ra;
    logic [31:0] din;

    logic [31:0] do_0, do_l3, do_wf, do_oor;
    logic        rv_0, rv_l3, rv_wf, rv_oor;
    logic        busy_0, busy_l3, busy_wf, busy_oor;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_dp_model #(.RD_LATENCY(1), .COLLISION_MODE(0)) dut (
        .clk(clk), .reset(reset), .chip_select(cs), .write_enable(we), .byte_enable(be),
        .wr_address(wa), .data_in(din), .rd_en(re), .rd_address(ra),
        .data_out(do_0), .rd_valid(rv_0), .clear_req(clr), .busy(busy_0));

    sram_dp_model #(.RD_LATENCY(3), .COLLISION_MODE(0)) dut_l3 (
        .clk(clk), .reset(reset), .chip_select(cs), .write_enable(we), .byte_enable(be),
        .wr_address(wa), .data_in(din), .rd_en(re), .rd_address(ra),
        .data_out(do_l3), .rd_valid(rv_l3), .clear_req(clr), .busy(busy_l3));

    sram_dp_model #(.RD_LATENCY(1), .COLLISION_MODE(1)) dut_wf (
        .clk(clk), .reset(reset), .chip_select(cs), .write_enable(we), .byte_enable(be),
        .wr_address(wa), .data_in(din), .rd_en(re), .rd_address(ra),
        .data_out(do_wf), .rd_valid(rv_wf), .clear_req(clr), .busy(busy_wf));

    sram_dp_model #(.DEPTH(6), .RD_LATENCY(1), .COLLISION_MODE(0)) dut_oor (
        .clk(clk), .reset(reset), .chip_select(cs), .write_enable(we), .byte_enable(be),
        .wr_address(wa), .data_in(din), .rd_en(re), .rd_address(ra),
        .data_out(do_oor), .rd_valid(rv_oor), .clear_req(clr), .busy(busy_oor));

    task automatic idle_inputs();
        cs = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
        be = '0; wa = '0; ra = '0; din = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; we = 1'b1; wa = a; din = d; be = b;
        step();
        we = 1'b0; be = '0;
    endtask

    task automatic read_word(input logic [2:0] a);
        cs = 1'b1; re = 1'b1; ra = a;
        step();
        re = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 8; i++) write_word(3'(i), 32'(10 + i), 4'hF);
    endtask

    task automatic test_reset();
        write_word(3'd1, 32'hDEADBEEF, 4'hF);
        write_word(3'd6, 32'h12345678, 4'hF);
        read_word(3'd1);
        checks++; if (do_0 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_read got=%h exp=%h", do_0, 32'hDEADBEEF); end
        reset = 1'b1;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem_q[i] !== 32'h0) begin failures++; $display("FAIL reset_mem[%0d] got=%h exp=0", i, dut.mem_q[i]); end
        end
        checks++; if (do_0 !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", do_0); end
        checks++; if (rv_0 !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rv_0); end
        checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_0); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_byte_write();
        write_word(3'd3, 32'hAABBCCDD, 4'hF);
        checks++; if (dut.mem_q[3] !== 32'hAABBCCDD) begin failures++; $display("FAIL full_write got=%h exp=%h", dut.mem_q[3], 32'hAABBCCDD); end
        write_word(3'd3, 32'h11223344, 4'b0101);
        checks++; if (dut.mem_q[3] !== 32'hAA22CC44) begin failures++; $display("FAIL byte_write got=%h exp=%h", dut.mem_q[3], 32'hAA22CC44); end
        write_word(3'd3, 32'hFFFFFFFF, 4'b0000);
        checks++; if (dut.mem_q[3] !== 32'hAA22CC44) begin failures++; $display("FAIL be_zero_noop got=%h exp=%h", dut.mem_q[3], 32'hAA22CC44); end
        read_word(3'd3);
        checks++; if (rv_0 !== 1'b1) begin failures++; $display("FAIL byte_read_valid got=%b exp=1", rv_0); end
        checks++; if (do_0 !== 32'hAA22CC44) begin failures++; $display("FAIL byte_read_data got=%h exp=%h", do_0, 32'hAA22CC44); end
        step();
        checks++; if (rv_0 !== 1'b0) begin failures++; $display("FAIL valid_one_cycle got=%b exp=0", rv_0); end
        checks++; if (do_0 !== 32'hAA22CC44) begin failures++; $display("FAIL data_hold got=%h exp=%h", do_0, 32'hAA22CC44); end
    endtask

    task automatic test_latency();
        logic        ev;
        logic [31:0] ed;
        fill_pattern();
        cs = 1'b1; re = 1'b1; ra = 3'd0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k < 7) ra = 3'(k + 1); else re = 1'b0;
            ev = (k >= 2 && k <= 9);
            checks++; if (rv_l3 !== ev) begin failures++; $display("FAIL lat3_valid k=%0d got=%b exp=%b", k, rv_l3, ev); end
            if (k >= 2) begin
                ed = 32'(10 + ((k - 2) > 7 ? 7 : (k - 2)));
                checks++; if (do_l3 !== ed) begin failures++; $display("FAIL lat3_data k=%0d got=%h exp=%h", k, do_l3, ed); end
            end
            ev = (k <= 7);
            ed = 32'(10 + (k > 7 ? 7 : k));
            checks++; if (rv_0 !== ev) begin failures++; $display("FAIL lat1_valid k=%0d got=%b exp=%b", k, rv_0, ev); end
            checks++; if (do_0 !== ed) begin failures++; $display("FAIL lat1_data k=%0d got=%h exp=%h", k, do_0, ed); end
        end
    endtask

    task automatic test_out_of_range();
        write_word(3'd6, 32'hCAFEF00D, 4'hF);
        checks++; if (dut_oor.mem_q[0] !== 32'd10) begin failures++; $display("FAIL oor_no_alias got=%h exp=%h", dut_oor.mem_q[0], 32'd10); end
        checks++; if (dut_oor.mem_q[5] !== 32'd15) begin failures++; $display("FAIL oor_last_word got=%h exp=%h", dut_oor.mem_q[5], 32'd15); end
        read_word(3'd5);
        checks++; if (do_oor !== 32'd15) begin failures++; $display("FAIL oor_last_read got=%h exp=%h", do_oor, 32'd15); end
        read_word(3'd7);
        checks++; if (rv_oor !== 1'b1) begin failures++; $display("FAIL oor_read_valid got=%b exp=1", rv_oor); end
        checks++; if (do_oor !== 32'h0) begin failures++; $display("FAIL oor_read_data got=%h exp=0", do_oor); end
    endtask

    task automatic test_collision();
        write_word(3'd5, 32'd7, 4'hF);
        cs = 1'b1; we = 1'b1; wa = 3'd5; din = 32'd99; be = 4'hF; re = 1'b1; ra = 3'd5;
        step();
        we = 1'b0; re = 1'b0;
        checks++; if (do_0 !== 32'd7) begin failures++; $display("FAIL coll_read_old got=%h exp=%h", do_0, 32'd7); end
        checks++; if (do_wf !== 32'd99) begin failures++; $display("FAIL coll_write_first got=%h exp=%h", do_wf, 32'd99); end
        checks++; if (rv_wf !== 1'b1) begin failures++; $display("FAIL coll_valid got=%b exp=1", rv_wf); end
        checks++; if (dut.mem_q[5] !== 32'd99) begin failures++; $display("FAIL coll_mem_m0 got=%h exp=%h", dut.mem_q[5], 32'd99); end
        checks++; if (dut_wf.mem_q[5] !== 32'd99) begin failures++; $display("FAIL coll_mem_m1 got=%h exp=%h", dut_wf.mem_q[5], 32'd99); end
        we = 1'b1; wa = 3'd5; din = 32'hAABBCCDD; be = 4'b0011; re = 1'b1; ra = 3'd5;
        step();
        we = 1'b0; re = 1'b0;
        checks++; if (do_0 !== 32'd99) begin failures++; $display("FAIL coll_part_old got=%h exp=%h", do_0, 32'd99); end
        checks++; if (do_wf !== 32'h0000CCDD) begin failures++; $display("FAIL coll_part_merge got=%h exp=%h", do_wf, 32'h0000CCDD); end
        we = 1'b1; wa = 3'd5; din = 32'd1; be = 4'hF; re = 1'b1; ra = 3'd4;
        step();
        we = 1'b0; re = 1'b0;
        checks++; if (do_wf !== 32'd14) begin failures++; $display("FAIL no_coll_m1 got=%h exp=%h", do_wf, 32'd14); end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int j;
        fill_pattern();
        cs = 1'b1; clr = 1'b1; re = 1'b1; ra = 3'd4;
        step();
        clr = 1'b0; re = 1'b0;
        checks++; if (busy_0 !== 1'b1) begin failures++; $display("FAIL clear_busy_start got=%b exp=1", busy_0); end
        checks++; if (rv_0 !== 1'b1 || do_0 !== 32'd14) begin failures++; $display("FAIL clear_edge_read got=%b/%h exp=1/%h", rv_0, do_0, 32'd14); end
        busy_cnt = (busy_0 === 1'b1) ? 1 : 0;
        j = 0;
        while (busy_0 === 1'b1 && j < 20) begin
            j++;
            if (j == 2) begin
                we = 1'b1; wa = 3'd2; din = 32'd55; be = 4'hF; re = 1'b1; ra = 3'd2;
            end else begin
                we = 1'b0; re = 1'b0;
            end
            step();
            checks++; if (rv_0 !== 1'b0) begin failures++; $display("FAIL clear_read_dropped j=%0d got=%b exp=0", j, rv_0); end
            checks++; if (rv_l3 !== (j == 2)) begin failures++; $display("FAIL clear_inflight_valid j=%0d got=%b exp=%b", j, rv_l3, j == 2); end
            if (j == 2) begin
                checks++; if (do_l3 !== 32'd14) begin failures++; $display("FAIL clear_inflight_data got=%h exp=%h", do_l3, 32'd14); end
            end
            if (busy_0 === 1'b1) busy_cnt++;
        end
        we = 1'b0; re = 1'b0;
        checks++; if (j >= 20) begin failures++; $display("FAIL clear_timeout busy still high after %0d cycles", j); end
        checks++; if (busy_cnt !== 8) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=8", busy_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem_q[i] !== 32'h0) begin failures++; $display("FAIL clear_mem[%0d] got=%h exp=0", i, dut.mem_q[i]); end
            read_word(3'(i));
            checks++; if (rv_0 !== 1'b1 || do_0 !== 32'h0) begin failures++; $display("FAIL clear_read[%0d] got=%b/%h exp=1/0", i, rv_0, do_0); end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_pattern();
        cs = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        step(); step(); step();
        checks++; if (busy_0 !== 1'b1) begin failures++; $display("FAIL mid_clear_busy got=%b exp=1", busy_0); end
        reset = 1'b1;
        #1;
        checks++; if (busy_0 !== 1'b0) begin failures++; $display("FAIL mid_clear_busy_reset got=%b exp=0", busy_0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem_q[i] !== 32'h0) begin failures++; $display("FAIL mid_clear_mem[%0d] got=%h exp=0", i, dut.mem_q[i]); end
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (rv_0 !== 1'b0 || rv_l3 !== 1'b0) begin failures++; $display("FAIL post_reset_valid k=%0d got=%b/%b exp=0/0", k, rv_0, rv_l3); end
        end
        write_word(3'd1, 32'h5A5A5A5A, 4'hF);
        read_word(3'd1);
        #2 reset = 1'b1;
        #1;
        checks++; if (rv_0 !== 1'b0) begin failures++; $display("FAIL mid_read_reset_valid got=%b exp=0", rv_0); end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (rv_l3 !== 1'b0) begin failures++; $display("FAIL mid_read_flushed k=%0d got=%b exp=0", k, rv_l3); end
        end
        read_word(3'd1);
        step(); step();
        checks++; if (rv_l3 !== 1'b1 || do_l3 !== 32'h0) begin failures++; $display("FAIL new_read_after_reset got=%b/%h exp=1/0", rv_l3, do_l3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        test_reset();
        test_byte_write();
        test_latency();
        test_out_of_range();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
